// File: rtl/free_list.sv
// Circular free list of physical-register tags with branch-recovery rollback to the retired state.
// Define FREE_LIST_DEBUG_EN to expose pointers, storage and a sticky protocol-error flag.
module free_list #(
    parameter int unsigned PREG_NUMBER    = 64,
    parameter int unsigned ARCHREG_NUMBER = 32,
    parameter int unsigned FL_SIZE        = PREG_NUMBER - ARCHREG_NUMBER,
    localparam int unsigned PW            = $clog2(PREG_NUMBER),
    localparam int unsigned FW            = $clog2(FL_SIZE)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [1:0]             dispatch_en_i,
    output logic [1:0][PW-1:0]     free_reg_o,
    output logic [1:0]             free_valid_o,
    input  logic [1:0]             retire_en_i,
    input  logic [1:0][PW-1:0]     T_old_i,
    input  logic                   branch_recover_i,
    output logic [FW:0]            free_count_o
`ifdef FREE_LIST_DEBUG_EN
    ,
    output logic [FW:0]            head_debug,
    output logic [FW:0]            tail_debug,
    output logic [FW:0]            arch_head_debug,
    output logic [FL_SIZE-1:0][PW-1:0] entries_debug,
    output logic                   error_o
`endif
);

    typedef logic [FW:0] ptr_t;

    logic [PW-1:0] entries_q [FL_SIZE];
    ptr_t head_q, head_d, tail_q, tail_d, arch_head_q, arch_head_d;
    ptr_t count, head_nxt, tail_w1, pop_cnt, push_cnt;
    logic push0, push1;

    // Outputs depend on registered state only; a tag reclaimed this cycle is not visible yet.
    always_comb begin
        count           = tail_q - head_q;
        free_count_o    = count;
        free_valid_o[0] = count > ptr_t'(0);
        free_valid_o[1] = count > ptr_t'(1);
        head_nxt        = head_q + ptr_t'(1);
        free_reg_o[0]   = entries_q[head_q[FW-1:0]];
        free_reg_o[1]   = entries_q[head_nxt[FW-1:0]];
    end

    always_comb begin
        // Preg 0 backs x0 and must never re-enter the pool.
        push0       = retire_en_i[0] && (T_old_i[0] != '0);
        push1       = retire_en_i[1] && (T_old_i[1] != '0);
        push_cnt    = ptr_t'(push0) + ptr_t'(push1);
        pop_cnt     = ptr_t'(dispatch_en_i[0] && free_valid_o[0])
                    + ptr_t'(dispatch_en_i[1] && free_valid_o[1]);
        tail_w1     = tail_q + ptr_t'(push0);
        tail_d      = tail_q + push_cnt;
        arch_head_d = arch_head_q + push_cnt;
        // On recovery every allocation younger than the retired point is handed back.
        head_d      = branch_recover_i ? arch_head_d : head_q + pop_cnt;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < FL_SIZE; i++) begin
                entries_q[i] <= PW'(ARCHREG_NUMBER + i);
            end
            head_q      <= '0;
            tail_q      <= ptr_t'(FL_SIZE);
            arch_head_q <= '0;
        end else begin
            if (push0) entries_q[tail_q[FW-1:0]] <= T_old_i[0];
            if (push1) entries_q[tail_w1[FW-1:0]] <= T_old_i[1];
            head_q      <= head_d;
            tail_q      <= tail_d;
            arch_head_q <= arch_head_d;
        end
    end

`ifdef FREE_LIST_DEBUG_EN
    logic          error_q;
    logic [FW+1:0] fill;

    assign fill = {1'b0, count} + {1'b0, push_cnt};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            error_q <= 1'b0;
        end else begin
            error_q <= error_q | (fill > (FW+2)'(FL_SIZE)) | (dispatch_en_i == 2'b10);
        end
    end

    assign error_o         = error_q;
    assign head_debug      = head_q;
    assign tail_debug      = tail_q;
    assign arch_head_debug = arch_head_q;

    always_comb begin
        entries_debug = '0;
        for (int unsigned i = 0; i < FL_SIZE; i++) begin
            entries_debug[i] = entries_q[i];
        end
    end
`endif

endmodule

// File: tb/tb_free_list.sv
// Self-checking bench for free_list: directed vector table, corner sequences and a random run
// against a queue-based model of the retired-onward tag order.
module tb_free_list;

    logic            clk = 1'b0;
    logic            reset;
    logic [1:0]      dispatch_en;
    logic [1:0][5:0] free_reg;
    logic [1:0]      free_valid;
    logic [1:0]      retire_en;
    logic [1:0][5:0] t_old;
    logic            branch_recover;
    logic [5:0]      free_count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    free_list dut (
        .clk              (clk),
        .reset            (reset),
        .dispatch_en_i    (dispatch_en),
        .free_reg_o       (free_reg),
        .free_valid_o     (free_valid),
        .retire_en_i      (retire_en),
        .T_old_i          (t_old),
        .branch_recover_i (branch_recover),
        .free_count_o     (free_count)
    );

    typedef struct {
        logic [1:0] disp;
        logic [1:0] ret;
        int         t0;
        int         t1;
        logic       rec;
        int         cnt;
        logic [1:0] vld;
        int         r0;
        int         r1;
    } vec_t;

    vec_t vecs[8];

    // Model: tags from the oldest non-retired allocation onward; the first 'alloc' are in flight.
    int q[$];
    int alloc;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] d, input logic [1:0] r, input int t0, input int t1,
                         input logic rec);
        dispatch_en    = d;
        retire_en      = r;
        t_old[0]       = 6'(t0);
        t_old[1]       = 6'(t1);
        branch_recover = rec;
    endtask

    task automatic do_reset();
        drive(2'b00, 2'b00, 0, 0, 1'b0);
        reset = 1'b0;
        step();
        reset = 1'b1;
    endtask

    task automatic check_out(input string tag, input int cnt, input int r0, input int r1);
        chk({tag, "_count"}, int'(free_count), cnt);
        chk({tag, "_valid"}, int'(free_valid), (cnt > 1) ? 3 : (cnt > 0 ? 1 : 0));
        if (cnt > 0) chk({tag, "_reg0"}, int'(free_reg[0]), r0);
        if (cnt > 1) chk({tag, "_reg1"}, int'(free_reg[1]), r1);
    endtask

    task automatic model_reset();
        q.delete();
        for (int i = 0; i < 32; i++) q.push_back(32 + i);
        alloc = 0;
    endtask

    initial begin
        vecs[0] = '{2'b00, 2'b00, 0,  0,  1'b0, 32, 2'b11, 32, 33};
        vecs[1] = '{2'b01, 2'b00, 0,  0,  1'b0, 31, 2'b11, 33, 34};
        vecs[2] = '{2'b11, 2'b00, 0,  0,  1'b0, 29, 2'b11, 35, 36};
        vecs[3] = '{2'b00, 2'b01, 0,  0,  1'b0, 29, 2'b11, 35, 36};
        vecs[4] = '{2'b11, 2'b11, 10, 12, 1'b0, 29, 2'b11, 37, 38};
        vecs[5] = '{2'b11, 2'b01, 5,  0,  1'b1, 32, 2'b11, 35, 36};
        vecs[6] = '{2'b11, 2'b00, 0,  0,  1'b0, 30, 2'b11, 37, 38};
        vecs[7] = '{2'b01, 2'b10, 0,  7,  1'b0, 30, 2'b11, 38, 39};

        drive(2'b00, 2'b00, 0, 0, 1'b0);
        reset = 1'b0;
        step();
        check_out("reset", 32, 32, 33);
        reset = 1'b1;

        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].disp, vecs[i].ret, vecs[i].t0, vecs[i].t1, vecs[i].rec);
            step();
            chk($sformatf("vec%0d_count", i), int'(free_count), vecs[i].cnt);
            chk($sformatf("vec%0d_valid", i), int'(free_valid), int'(vecs[i].vld));
            chk($sformatf("vec%0d_reg0", i), int'(free_reg[0]), vecs[i].r0);
            chk($sformatf("vec%0d_reg1", i), int'(free_reg[1]), vecs[i].r1);
        end

        // Drain, over-request when empty, refill from empty, then a one-free dual request.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            check_out($sformatf("drain%0d", i), 32 - 2 * i, 32 + 2 * i, 33 + 2 * i);
            drive(2'b11, 2'b00, 0, 0, 1'b0);
            step();
        end
        check_out("empty", 0, 0, 0);
        step();
        check_out("empty_req", 0, 0, 0);
        drive(2'b00, 2'b11, 5, 7, 1'b0);
        step();
        check_out("refill", 2, 5, 7);
        drive(2'b01, 2'b00, 0, 0, 1'b0);
        step();
        check_out("one_left", 1, 7, 0);
        drive(2'b11, 2'b11, 8, 9, 1'b0);
        step();
        check_out("one_dual", 2, 8, 9);

        // Recovery with a same-cycle retire; the reclaimed tag lands in wrapped slot 0.
        do_reset();
        drive(2'b11, 2'b00, 0, 0, 1'b0);
        step();
        step();
        drive(2'b11, 2'b01, 3, 0, 1'b1);
        step();
        check_out("recover", 32, 33, 34);
        for (int i = 0; i < 16; i++) begin
            check_out($sformatf("rdrain%0d", i), 32 - 2 * i, 33 + 2 * i, (i == 15) ? 3 : 34 + 2 * i);
            drive(2'b11, 2'b00, 0, 0, 1'b0);
            step();
        end
        check_out("rdrain_end", 0, 0, 0);

        // Asynchronous reset between edges, then first cycle after release.
        do_reset();
        drive(2'b11, 2'b00, 0, 0, 1'b0);
        step();
        step();
        step();
        #2;
        reset = 1'b0;
        #1;
        check_out("async_rst", 32, 32, 33);
        drive(2'b00, 2'b00, 0, 0, 1'b0);
        step();
        reset = 1'b1;
        drive(2'b01, 2'b00, 0, 0, 1'b0);
        step();
        check_out("post_rst", 31, 33, 34);

        // Random legal traffic: retires never exceed in-flight allocations.
        do_reset();
        model_reset();
        for (int c = 0; c < 500; c++) begin
            int fc, pop, np, sel, t0, t1;
            logic [1:0] d, r;
            logic rec;
            fc  = 32 - alloc;
            sel = int'($urandom_range(0, 2));
            d   = (sel == 0) ? 2'b00 : (sel == 1 ? 2'b01 : 2'b11);
            rec = ($urandom_range(0, 9) == 0);
            r   = 2'($urandom_range(0, 3));
            t0  = int'($urandom_range(0, 63));
            t1  = int'($urandom_range(0, 63));
            np  = int'(r[0] && t0 != 0) + int'(r[1] && t1 != 0);
            if (np > alloc) r[1] = 1'b0;
            np  = int'(r[0] && t0 != 0) + int'(r[1] && t1 != 0);
            if (np > alloc) r[0] = 1'b0;
            np  = int'(r[0] && t0 != 0) + int'(r[1] && t1 != 0);
            drive(d, r, t0, t1, rec);
            step();
            pop = rec ? 0 : int'(d[0] && fc > 0) + int'(d[1] && fc > 1);
            alloc = rec ? 0 : alloc + pop - np;
            for (int k = 0; k < np; k++) void'(q.pop_front());
            if (r[0] && t0 != 0) q.push_back(t0);
            if (r[1] && t1 != 0) q.push_back(t1);
            fc = 32 - alloc;
            check_out($sformatf("rand%0d", c), fc,
                      (fc > 0) ? q[alloc] : 0, (fc > 1) ? q[alloc + 1] : 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/free_list.md
Name: free_list

Overview:
- Circular FIFO of free physical-register tags; it is the other end of the ROB retire interface.
- Supplies up to two renamed tags per cycle to dispatch, i.e. the ROB freeReg_i / Map Table inputs.
- Reclaims up to two T_old tags per cycle from ROB retire outputs T_old_o / retire_en_o.
- Restores the architectural free-list state on branch recovery.

Parameters:
PREG_NUMBER, 64, number of physical registers; tag width PW = clog2(PREG_NUMBER)
ARCHREG_NUMBER, 32, number of architectural registers
FL_SIZE, PREG_NUMBER-ARCHREG_NUMBER, free-list capacity; power of two; FW = clog2(FL_SIZE)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
dispatch_en_i  input  2  allocation request; [1] asserted only with [0]
free_reg_o  output  2xPW  tags at head and head+1
free_valid_o  output  2  free_reg_o[k] valid
retire_en_i  input  2  from ROB retire_en_o
T_old_i  input  2xPW  from ROB T_old_o; tag to reclaim
branch_recover_i  input  1  squash all in-flight allocations
free_count_o  output  FW+1  number of free tags, 0..FL_SIZE

Behaviour:
State:
- Storage: entries[FL_SIZE] x PW.
- Pointers: head, tail, arch_head; each FW+1 bits, MSB is the wrap bit.
- Count: free_count_o = tail - head, modulo 2^(FW+1).

Reset (reset==0, asynchronous):
- entries[i] = ARCHREG_NUMBER + i.
- head = arch_head = 0; tail = FL_SIZE (full).
- free_count_o = FL_SIZE; free_valid_o = 2'b11; free_reg_o = {ARCHREG_NUMBER+1, ARCHREG_NUMBER}.

Outputs:
- free_reg_o and free_valid_o are combinational from registered state only. There is no retire-to-dispatch bypass.
- free_valid_o[k] = (free_count_o > k).

Allocation:
- pop = number of k with dispatch_en_i[k] && free_valid_o[k].
- head += pop at the clock edge.
- A request with free_valid_o[k]==0 is dropped silently; dispatch must stall on free_valid_o.

Reclaim:
- Slot k is reclaimed iff retire_en_i[k] && T_old_i[k] != 0.
- Preg 0 maps x0 and is never freed.
- Reclaimed tags are written at tail, then tail+1, in slot order; tail += push count.
- arch_head advances by the same push count. Allocation and retirement are both in order, so arch_head marks the oldest non-retired allocation.
- Tags become visible on free_reg_o the cycle after the push.

Recovery (branch_recover_i==1):
- dispatch_en_i is ignored.
- Retires presented in the same cycle are still processed. They are older than the branch because ROB retire outputs are registered.
- Next state: head = arch_head + push count of this cycle. tail and arch_head update normally.
- Result: every in-flight allocation is returned.

Simultaneous pop and push:
- Both are applied in one cycle.
- Pushes never exceed FL_SIZE by construction (conservation of tags). A push when free_count_o==FL_SIZE is a protocol violation; state after it is undefined.

Wrap-around: all pointer arithmetic is modulo 2^(FW+1); index = pointer[FW-1:0].

Reset mid-operation: all state returns immediately to the reset values; the first edge after release behaves as the first cycle after reset.

Optional Feature:
Macro FREE_LIST_DEBUG_EN.
- Defined: extra outputs head_debug (FW+1), tail_debug (FW+1), arch_head_debug (FW+1), entries_debug (FL_SIZE x PW). Also an error_o sticky bit that sets on push-overflow or on dispatch_en_i==2'b10, clears only on reset, and resets to 0.
- Undefined: these ports and logic are absent; functional behaviour is identical.

Test Plan:
- Reset, then idle -> free_reg_o={33,32}, free_valid_o=11, free_count_o=32.
- dispatch_en_i=11 for 16 cycles -> tags 32..63 issued in order, free_count_o=0, free_valid_o=00. A further request leaves head unchanged.
- From empty: retire_en_i=11, T_old_i={7,5} -> next cycle free_reg_o={7,5}, free_count_o=2.
- After reset: allocate 4 (32..35). Then one cycle with retire_en_i=01, T_old_i[0]=3 and branch_recover_i=1 -> free_count_o=32, free_reg_o={34,33}, tag 3 at slot 0 (wrapped).
- free_count_o=1, dispatch_en_i=11, retire_en_i=11 with T_old_i={9,8} -> only tag at head accepted, next free_count_o=2, free_reg_o={9,8}.
- Drop reset mid-burst between clock edges -> outputs return to reset values immediately, without waiting for clk.
